// File: rtl/control_unit_if.sv
// Control bundle between the sequencer and the single-bus datapath: IR/con_ff/stop in,
// every bus-source, load-enable, select, memory and ALU-op strobe out.
interface control_unit_if #(
   parameter int IR_W = 32
);
   // No valid/ready handshake: every strobe is a level that is valid for the whole state
   // (one clk) in which it is high; the datapath acts on it at the closing posedge.
   logic [IR_W-1:0] IR;
   logic            con_ff;
   logic            stop;
   logic            run;
   logic            PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout, BAout;
   logic            PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OutPort;
   logic            Gra, Grb, Grc, Rin, Rout;
   logic            read, write;
   logic            AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC;
   logic [3:0]      dbg_state;

   modport master (
      input  IR, con_ff, stop,
      output run,
      output PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout, BAout,
      output PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OutPort,
      output Gra, Grb, Grc, Rin, Rout,
      output read, write,
      output AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC,
      output dbg_state
   );

   modport slave (
      output IR, con_ff, stop,
      input  run,
      input  PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout, BAout,
      input  PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OutPort,
      input  Gra, Grb, Grc, Rin, Rout,
      input  read, write,
      input  AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC,
      input  dbg_state
   );
endinterface

// File: rtl/control_unit.sv
// Moore sequencer for the 32-bit single-bus datapath: fetch T0-T2, decode, execute T3-T7.
// Strobes are decoded combinationally from the state, the IR opcode and con_ff.
module control_unit #(
   parameter int IR_W          = 32,
   parameter int OPC_LSB       = 27,
   parameter bit HALT_ON_UNDEF = 1'b0
) (
   input  logic           clk,
   input  logic           clear,
   control_unit_if.master cu
);

   typedef enum logic [3:0] {
      S_RESET      = 4'd0,
      S_FETCH_WAIT = 4'd1,
      S_T0         = 4'd2,
      S_T1         = 4'd3,
      S_T2         = 4'd4,
      S_T3         = 4'd5,
      S_T4         = 4'd6,
      S_T5         = 4'd7,
      S_T6         = 4'd8,
      S_T7         = 4'd9,
      S_HALT       = 4'd10
   } state_t;

   typedef enum logic [3:0] {
      C_LD, C_LDI, C_ST, C_ALU_R, C_ALU_I, C_MULDIV, C_NEGNOT, C_BR,
      C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
   } class_t;

   localparam int SRC_PC = 0, SRC_MDR = 1, SRC_ZHI = 2, SRC_ZLO = 3, SRC_HI = 4;
   localparam int SRC_LO = 5, SRC_INP = 6, SRC_C = 7, SRC_BA = 8;
   localparam int LD_PC = 0, LD_IR = 1, LD_MAR = 2, LD_MDR = 3, LD_Y = 4;
   localparam int LD_Z = 5, LD_HI = 6, LD_LO = 7, LD_CON = 8, LD_OUT = 9;
   localparam int SEL_GRA = 0, SEL_GRB = 1, SEL_GRC = 2, SEL_RIN = 3, SEL_ROUT = 4;
   localparam int A_AND = 0, A_OR = 1, A_ADD = 2, A_SUB = 3, A_MUL = 4, A_DIV = 5, A_SHR = 6;
   localparam int A_SHL = 7, A_ROR = 8, A_ROL = 9, A_NEG = 10, A_NOT = 11, A_INC = 12;

   state_t      state_q, state_d;
   class_t      cls;
   state_t      last_step;
   state_t      boundary;
   logic [4:0]  opcode;
   logic [12:0] op_sel;
   logic [8:0]  src;
   logic [9:0]  ldv;
   logic [4:0]  sel;
   logic [12:0] alu;
   logic        rd, wr;
   logic        unused_ir_low;

   assign opcode        = cu.IR[IR_W-1:OPC_LSB];
   assign unused_ir_low = ^cu.IR[OPC_LSB-1:0];

   // Opcode to instruction class, plus the one-hot ALU op the class uses in its op step.
   always_comb begin
      cls    = C_NOP;
      op_sel = '0;
      case (opcode)
         5'b00000: cls = C_LD;
         5'b00001: cls = C_LDI;
         5'b00010: cls = C_ST;
         5'b00011: begin cls = C_ALU_R;  op_sel[A_ADD] = 1'b1; end
         5'b00100: begin cls = C_ALU_R;  op_sel[A_SUB] = 1'b1; end
         5'b00101: begin cls = C_ALU_R;  op_sel[A_AND] = 1'b1; end
         5'b00110: begin cls = C_ALU_R;  op_sel[A_OR]  = 1'b1; end
         5'b00111: begin cls = C_ALU_R;  op_sel[A_SHR] = 1'b1; end
         5'b01000: begin cls = C_ALU_R;  op_sel[A_SHL] = 1'b1; end
         5'b01001: begin cls = C_ALU_R;  op_sel[A_ROR] = 1'b1; end
         5'b01010: begin cls = C_ALU_R;  op_sel[A_ROL] = 1'b1; end
         5'b01011: begin cls = C_ALU_I;  op_sel[A_ADD] = 1'b1; end
         5'b01100: begin cls = C_ALU_I;  op_sel[A_AND] = 1'b1; end
         5'b01101: begin cls = C_ALU_I;  op_sel[A_OR]  = 1'b1; end
         5'b01110: begin cls = C_MULDIV; op_sel[A_MUL] = 1'b1; end
         5'b01111: begin cls = C_MULDIV; op_sel[A_DIV] = 1'b1; end
         5'b10000: begin cls = C_NEGNOT; op_sel[A_NEG] = 1'b1; end
         5'b10001: begin cls = C_NEGNOT; op_sel[A_NOT] = 1'b1; end
         5'b10010: cls = C_BR;
         5'b10011: cls = C_JR;
         5'b10100: cls = C_IN;
         5'b10101: cls = C_OUT;
         5'b10110: cls = C_MFHI;
         5'b10111: cls = C_MFLO;
         5'b11000: cls = C_NOP;
         5'b11001: cls = C_HALT;
         default:  cls = HALT_ON_UNDEF ? C_HALT : C_NOP;
      endcase
   end

   always_comb begin
      case (cls)
         C_LD, C_ST:                  last_step = S_T7;
         C_LDI, C_ALU_R, C_ALU_I:     last_step = S_T5;
         C_MULDIV, C_BR:              last_step = S_T6;
         C_NEGNOT:                    last_step = S_T4;
         default:                     last_step = S_T3;
      endcase
   end

   // stop only matters here, where one instruction ends and the next would begin.
   assign boundary = cu.stop ? S_FETCH_WAIT : S_T0;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET:      state_d = boundary;
         S_FETCH_WAIT: state_d = boundary;
         S_T0:         state_d = S_T1;
         S_T1:         state_d = S_T2;
         S_T2:         state_d = (cls == C_NOP) ? boundary : S_T3;
         S_T3, S_T4, S_T5, S_T6, S_T7: begin
            if (cls == C_HALT)
               state_d = S_HALT;
            else if (state_q == last_step)
               state_d = boundary;
            else
               state_d = state_t'(state_q + 4'd1);
         end
         S_HALT:       state_d = S_HALT;
         default:      state_d = S_RESET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clear)
         state_q <= S_RESET;
      else
         state_q <= state_d;
   end

   always_comb begin
      src = '0;
      ldv = '0;
      sel = '0;
      alu = '0;
      rd  = 1'b0;
      wr  = 1'b0;
      case (state_q)
         S_T0: begin
            src[SRC_PC] = 1'b1; ldv[LD_MAR] = 1'b1; alu[A_INC] = 1'b1; ldv[LD_Z] = 1'b1;
         end
         S_T1: begin
            src[SRC_ZLO] = 1'b1; ldv[LD_PC] = 1'b1; rd = 1'b1; ldv[LD_MDR] = 1'b1;
         end
         S_T2: begin
            src[SRC_MDR] = 1'b1; ldv[LD_IR] = 1'b1;
         end
         S_T3: begin
            case (cls)
               C_ALU_R, C_ALU_I: begin sel[SEL_GRB] = 1'b1; sel[SEL_ROUT] = 1'b1; ldv[LD_Y] = 1'b1; end
               C_MULDIV:         begin sel[SEL_GRA] = 1'b1; sel[SEL_ROUT] = 1'b1; ldv[LD_Y] = 1'b1; end
               C_NEGNOT: begin
                  sel[SEL_GRB] = 1'b1; sel[SEL_ROUT] = 1'b1; alu = op_sel; ldv[LD_Z] = 1'b1;
               end
               C_LD, C_LDI, C_ST: begin sel[SEL_GRB] = 1'b1; src[SRC_BA] = 1'b1; ldv[LD_Y] = 1'b1; end
               C_BR:   begin sel[SEL_GRA] = 1'b1; sel[SEL_ROUT] = 1'b1; ldv[LD_CON] = 1'b1; end
               C_JR:   begin sel[SEL_GRA] = 1'b1; sel[SEL_ROUT] = 1'b1; ldv[LD_PC] = 1'b1; end
               C_IN:   begin src[SRC_INP] = 1'b1; sel[SEL_GRA] = 1'b1; sel[SEL_RIN] = 1'b1; end
               C_OUT:  begin sel[SEL_GRA] = 1'b1; sel[SEL_ROUT] = 1'b1; ldv[LD_OUT] = 1'b1; end
               C_MFHI: begin src[SRC_HI] = 1'b1; sel[SEL_GRA] = 1'b1; sel[SEL_RIN] = 1'b1; end
               C_MFLO: begin src[SRC_LO] = 1'b1; sel[SEL_GRA] = 1'b1; sel[SEL_RIN] = 1'b1; end
               default: ;
            endcase
         end
         S_T4: begin
            case (cls)
               C_ALU_R: begin
                  sel[SEL_GRC] = 1'b1; sel[SEL_ROUT] = 1'b1; alu = op_sel; ldv[LD_Z] = 1'b1;
               end
               C_ALU_I:  begin src[SRC_C] = 1'b1; alu = op_sel; ldv[LD_Z] = 1'b1; end
               C_MULDIV: begin
                  sel[SEL_GRB] = 1'b1; sel[SEL_ROUT] = 1'b1; alu = op_sel; ldv[LD_Z] = 1'b1;
               end
               C_NEGNOT: begin src[SRC_ZLO] = 1'b1; sel[SEL_GRA] = 1'b1; sel[SEL_RIN] = 1'b1; end
               C_LD, C_LDI, C_ST: begin src[SRC_C] = 1'b1; alu[A_ADD] = 1'b1; ldv[LD_Z] = 1'b1; end
               C_BR:     begin src[SRC_PC] = 1'b1; ldv[LD_Y] = 1'b1; end
               default: ;
            endcase
         end
         S_T5: begin
            case (cls)
               C_ALU_R, C_ALU_I, C_LDI: begin
                  src[SRC_ZLO] = 1'b1; sel[SEL_GRA] = 1'b1; sel[SEL_RIN] = 1'b1;
               end
               C_MULDIV:   begin src[SRC_ZLO] = 1'b1; ldv[LD_LO] = 1'b1; end
               C_LD, C_ST: begin src[SRC_ZLO] = 1'b1; ldv[LD_MAR] = 1'b1; end
               C_BR:       begin src[SRC_C] = 1'b1; alu[A_ADD] = 1'b1; ldv[LD_Z] = 1'b1; end
               default: ;
            endcase
         end
         S_T6: begin
            case (cls)
               C_MULDIV: begin src[SRC_ZHI] = 1'b1; ldv[LD_HI] = 1'b1; end
               C_LD:     begin rd = 1'b1; ldv[LD_MDR] = 1'b1; end
               C_ST:     begin sel[SEL_GRA] = 1'b1; sel[SEL_ROUT] = 1'b1; ldv[LD_MDR] = 1'b1; end
               // A branch not taken spends T6 idle so taken and not-taken cost the same.
               C_BR: begin
                  if (cu.con_ff) begin
                     src[SRC_ZLO] = 1'b1; ldv[LD_PC] = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         S_T7: begin
            case (cls)
               C_LD: begin src[SRC_MDR] = 1'b1; sel[SEL_GRA] = 1'b1; sel[SEL_RIN] = 1'b1; end
               C_ST: wr = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign cu.run       = (state_q != S_RESET) && (state_q != S_FETCH_WAIT) && (state_q != S_HALT);
   assign cu.dbg_state = state_q;

   assign cu.PCout     = src[SRC_PC];
   assign cu.MDRout    = src[SRC_MDR];
   assign cu.Zhighout  = src[SRC_ZHI];
   assign cu.Zlowout   = src[SRC_ZLO];
   assign cu.HIout     = src[SRC_HI];
   assign cu.LOout     = src[SRC_LO];
   assign cu.Inportout = src[SRC_INP];
   assign cu.Cout      = src[SRC_C];
   assign cu.BAout     = src[SRC_BA];

   assign cu.PCin      = ldv[LD_PC];
   assign cu.IRin      = ldv[LD_IR];
   assign cu.MARin     = ldv[LD_MAR];
   assign cu.MDRin     = ldv[LD_MDR];
   assign cu.Yin       = ldv[LD_Y];
   assign cu.Zin       = ldv[LD_Z];
   assign cu.HIin      = ldv[LD_HI];
   assign cu.LOin      = ldv[LD_LO];
   assign cu.CONin     = ldv[LD_CON];
   assign cu.OutPort   = ldv[LD_OUT];

   assign cu.Gra       = sel[SEL_GRA];
   assign cu.Grb       = sel[SEL_GRB];
   assign cu.Grc       = sel[SEL_GRC];
   assign cu.Rin       = sel[SEL_RIN];
   assign cu.Rout      = sel[SEL_ROUT];

   assign cu.read      = rd;
   assign cu.write     = wr;

   assign cu.AND       = alu[A_AND];
   assign cu.OR        = alu[A_OR];
   assign cu.ADD       = alu[A_ADD];
   assign cu.SUB       = alu[A_SUB];
   assign cu.MUL       = alu[A_MUL];
   assign cu.DIV       = alu[A_DIV];
   assign cu.SHR       = alu[A_SHR];
   assign cu.SHL       = alu[A_SHL];
   assign cu.ROR       = alu[A_ROR];
   assign cu.ROL       = alu[A_ROL];
   assign cu.NEG       = alu[A_NEG];
   assign cu.NOT       = alu[A_NOT];
   assign cu.IncPC     = alu[A_INC];

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a per-cycle control-word model feeds an expected queue that is
// popped and compared against the strobes every cycle, plus per-cycle invariant checks.
module tb_control_unit;

  logic clk;
  logic clear;
  int   n_checks;
  int   n_fail;
  logic [39:0] exp_q[$];

  control_unit_if #(.IR_W(32)) cu_bus ();

  control_unit #(.IR_W(32), .OPC_LSB(27), .HALT_ON_UNDEF(1'b0)) dut (
    .clk   (clk),
    .clear (clear),
    .cu    (cu_bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- control word layout ----------------
  localparam logic [39:0] M_PCOUT = 40'h1 << 0,  M_MDROUT = 40'h1 << 1,  M_ZHIGHOUT = 40'h1 << 2;
  localparam logic [39:0] M_ZLOWOUT = 40'h1 << 3, M_HIOUT = 40'h1 << 4,  M_LOOUT = 40'h1 << 5;
  localparam logic [39:0] M_INPORTOUT = 40'h1 << 6, M_COUT = 40'h1 << 7, M_BAOUT = 40'h1 << 8;
  localparam logic [39:0] M_PCIN = 40'h1 << 9,   M_IRIN = 40'h1 << 10,   M_MARIN = 40'h1 << 11;
  localparam logic [39:0] M_MDRIN = 40'h1 << 12, M_YIN = 40'h1 << 13,    M_ZIN = 40'h1 << 14;
  localparam logic [39:0] M_HIIN = 40'h1 << 15,  M_LOIN = 40'h1 << 16,   M_CONIN = 40'h1 << 17;
  localparam logic [39:0] M_OUTPORT = 40'h1 << 18;
  localparam logic [39:0] M_GRA = 40'h1 << 19,   M_GRB = 40'h1 << 20,    M_GRC = 40'h1 << 21;
  localparam logic [39:0] M_RIN = 40'h1 << 22,   M_ROUT = 40'h1 << 23;
  localparam logic [39:0] M_READ = 40'h1 << 24,  M_WRITE = 40'h1 << 25;
  localparam logic [39:0] M_AND = 40'h1 << 26,   M_OR = 40'h1 << 27,     M_ADD = 40'h1 << 28;
  localparam logic [39:0] M_SUB = 40'h1 << 29,   M_MUL = 40'h1 << 30,    M_DIV = 40'h1 << 31;
  localparam logic [39:0] M_SHR = 40'h1 << 32,   M_SHL = 40'h1 << 33,    M_ROR = 40'h1 << 34;
  localparam logic [39:0] M_ROL = 40'h1 << 35,   M_NEG = 40'h1 << 36,    M_NOT = 40'h1 << 37;
  localparam logic [39:0] M_INCPC = 40'h1 << 38, M_RUN = 40'h1 << 39;

  localparam logic [39:0] W_T0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [39:0] W_T1 = M_RUN | M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
  localparam logic [39:0] W_T2 = M_RUN | M_MDROUT | M_IRIN;

  function automatic logic [39:0] observe();
    logic [39:0] w;
    w = '0;
    w[0]  = cu_bus.PCout;   w[1]  = cu_bus.MDRout;  w[2]  = cu_bus.Zhighout; w[3] = cu_bus.Zlowout;
    w[4]  = cu_bus.HIout;   w[5]  = cu_bus.LOout;   w[6]  = cu_bus.Inportout;
    w[7]  = cu_bus.Cout;    w[8]  = cu_bus.BAout;
    w[9]  = cu_bus.PCin;    w[10] = cu_bus.IRin;    w[11] = cu_bus.MARin;    w[12] = cu_bus.MDRin;
    w[13] = cu_bus.Yin;     w[14] = cu_bus.Zin;     w[15] = cu_bus.HIin;     w[16] = cu_bus.LOin;
    w[17] = cu_bus.CONin;   w[18] = cu_bus.OutPort;
    w[19] = cu_bus.Gra;     w[20] = cu_bus.Grb;     w[21] = cu_bus.Grc;
    w[22] = cu_bus.Rin;     w[23] = cu_bus.Rout;
    w[24] = cu_bus.read;    w[25] = cu_bus.write;
    w[26] = cu_bus.AND;     w[27] = cu_bus.OR;      w[28] = cu_bus.ADD;      w[29] = cu_bus.SUB;
    w[30] = cu_bus.MUL;     w[31] = cu_bus.DIV;     w[32] = cu_bus.SHR;      w[33] = cu_bus.SHL;
    w[34] = cu_bus.ROR;     w[35] = cu_bus.ROL;     w[36] = cu_bus.NEG;      w[37] = cu_bus.NOT;
    w[38] = cu_bus.IncPC;   w[39] = cu_bus.run;
    return w;
  endfunction

  // ---------------- invariant monitor ----------------
  always @(negedge clk) begin
    #2;
    n_checks += 3;
    if ($countones({cu_bus.PCout, cu_bus.MDRout, cu_bus.Zhighout, cu_bus.Zlowout, cu_bus.HIout,
                    cu_bus.LOout, cu_bus.Inportout, cu_bus.Cout, cu_bus.BAout, cu_bus.Rout}) > 1) begin
      n_fail++;
      $display("FAIL inv_bus_source: got %h expected at most one source", observe());
    end
    if ($countones({cu_bus.AND, cu_bus.OR, cu_bus.ADD, cu_bus.SUB, cu_bus.MUL, cu_bus.DIV,
                    cu_bus.SHR, cu_bus.SHL, cu_bus.ROR, cu_bus.ROL, cu_bus.NEG, cu_bus.NOT,
                    cu_bus.IncPC}) > 1) begin
      n_fail++;
      $display("FAIL inv_alu_op: got %h expected at most one op", observe());
    end
    if (cu_bus.read && cu_bus.write) begin
      n_fail++;
      $display("FAIL inv_read_write: got read=1 write=1 expected not both");
    end
  end

  // ---------------- scoreboard model ----------------
  task automatic push_instr(input logic [31:0] ir, input logic con);
    logic [4:0]  opc;
    logic [39:0] op;
    opc = ir[31:27];
    op  = '0;
    exp_q.push_back(W_T0);
    exp_q.push_back(W_T1);
    exp_q.push_back(W_T2);
    case (opc)
      5'd3: op = M_ADD;  5'd4: op = M_SUB;  5'd5: op = M_AND;  5'd6: op = M_OR;
      5'd7: op = M_SHR;  5'd8: op = M_SHL;  5'd9: op = M_ROR;  5'd10: op = M_ROL;
      5'd11: op = M_ADD; 5'd12: op = M_AND; 5'd13: op = M_OR;
      5'd14: op = M_MUL; 5'd15: op = M_DIV; 5'd16: op = M_NEG; 5'd17: op = M_NOT;
      default: op = '0;
    endcase
    if (opc <= 5'd2) begin
      exp_q.push_back(M_RUN | M_GRB | M_BAOUT | M_YIN);
      exp_q.push_back(M_RUN | M_COUT | M_ADD | M_ZIN);
      if (opc == 5'd1) begin
        exp_q.push_back(M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
      end else begin
        exp_q.push_back(M_RUN | M_ZLOWOUT | M_MARIN);
        if (opc == 5'd0) begin
          exp_q.push_back(M_RUN | M_READ | M_MDRIN);
          exp_q.push_back(M_RUN | M_MDROUT | M_GRA | M_RIN);
        end else begin
          exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_MDRIN);
          exp_q.push_back(M_RUN | M_WRITE);
        end
      end
    end else if (opc <= 5'd10) begin
      exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
      exp_q.push_back(M_RUN | M_GRC | M_ROUT | op | M_ZIN);
      exp_q.push_back(M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
    end else if (opc <= 5'd13) begin
      exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
      exp_q.push_back(M_RUN | M_COUT | op | M_ZIN);
      exp_q.push_back(M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
    end else if (opc <= 5'd15) begin
      exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_YIN);
      exp_q.push_back(M_RUN | M_GRB | M_ROUT | op | M_ZIN);
      exp_q.push_back(M_RUN | M_ZLOWOUT | M_LOIN);
      exp_q.push_back(M_RUN | M_ZHIGHOUT | M_HIIN);
    end else if (opc <= 5'd17) begin
      exp_q.push_back(M_RUN | M_GRB | M_ROUT | op | M_ZIN);
      exp_q.push_back(M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
    end else begin
      case (opc)
        5'd18: begin
          exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_CONIN);
          exp_q.push_back(M_RUN | M_PCOUT | M_YIN);
          exp_q.push_back(M_RUN | M_COUT | M_ADD | M_ZIN);
          exp_q.push_back(con ? (M_RUN | M_ZLOWOUT | M_PCIN) : M_RUN);
        end
        5'd19: exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_PCIN);
        5'd20: exp_q.push_back(M_RUN | M_INPORTOUT | M_GRA | M_RIN);
        5'd21: exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_OUTPORT);
        5'd22: exp_q.push_back(M_RUN | M_HIOUT | M_GRA | M_RIN);
        5'd23: exp_q.push_back(M_RUN | M_LOOUT | M_GRA | M_RIN);
        5'd25: exp_q.push_back(M_RUN);
        default: ;
      endcase
    end
  endtask

  // ---------------- drivers ----------------
  // Entry: just after a negedge with the DUT in T0. Exit: one cycle after the last step.
  task automatic run_instr(input logic [31:0] ir, input logic con, input bit chk_boundary,
                           input int stop_at, input string tag);
    logic [39:0] exp_w;
    logic [39:0] obs;
    int k;
    cu_bus.IR     = ir;
    cu_bus.con_ff = con;
    push_instr(ir, con);
    k = 0;
    while (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      obs   = observe();
      n_checks++;
      if (obs !== exp_w) begin
        n_fail++;
        $display("FAIL %s step %0d ir=%h: got %h expected %h", tag, k, ir, obs, exp_w);
      end
      if (k == stop_at) cu_bus.stop = 1'b1;
      k++;
      @(negedge clk); #1;
    end
    if (chk_boundary) begin
      obs = observe();
      n_checks++;
      if (obs !== W_T0) begin
        n_fail++;
        $display("FAIL %s boundary ir=%h: got %h expected %h", tag, ir, obs, W_T0);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [39:0] obs;
    clear = 1'b0;
    cu_bus.stop = 1'b0;
    cu_bus.con_ff = 1'b0;
    cu_bus.IR = 32'h0;
    repeat (2) begin
      @(negedge clk); #1;
      obs = observe();
      n_checks++;
      if (obs !== 40'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h expected %h", obs, 40'h0);
      end
    end
    clear = 1'b1;
    @(negedge clk); #1;
    obs = observe();
    n_checks++;
    if (obs !== W_T0) begin
      n_fail++;
      $display("FAIL reset_release_t0: got %h expected %h", obs, W_T0);
    end
  endtask

  task automatic test_spec_examples();
    run_instr(32'h1A2B8000, 1'b0, 1'b1, -1, "add_r4_r5_r7");
    run_instr(32'h00800055, 1'b0, 1'b1, -1, "ld_r1_55_r0");
    run_instr({5'b10010, 27'h0123456}, 1'b0, 1'b1, -1, "br_not_taken");
    run_instr({5'b10010, 27'h0123456}, 1'b1, 1'b1, -1, "br_taken");
  endtask

  task automatic test_all_opcodes();
    for (int opc = 0; opc < 32; opc++) begin
      if (opc != 25)
        run_instr({opc[4:0], 27'($urandom_range(0, 32'h07FF_FFFF))}, 1'($urandom_range(0, 1)),
                  1'b1, -1, "opcode_sweep");
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] opc;
    for (int i = 0; i < 24; i++) begin
      opc = 5'($urandom_range(0, 24));
      run_instr({opc, 27'($urandom_range(0, 32'h07FF_FFFF))}, 1'($urandom_range(0, 1)),
                1'b1, -1, "back_to_back");
    end
  endtask

  task automatic test_stop_boundary();
    logic [39:0] obs;
    run_instr({5'b11000, 27'h0}, 1'b0, 1'b0, 0, "nop_with_stop");
    repeat (3) begin
      obs = observe();
      n_checks++;
      if (obs !== 40'h0) begin
        n_fail++;
        $display("FAIL stop_fetch_wait: got %h expected %h", obs, 40'h0);
      end
      @(negedge clk); #1;
    end
    cu_bus.stop = 1'b0;
    @(negedge clk); #1;
    obs = observe();
    n_checks++;
    if (obs !== W_T0) begin
      n_fail++;
      $display("FAIL stop_release_t0: got %h expected %h", obs, W_T0);
    end
  endtask

  task automatic test_clear_abort();
    logic [39:0] exp_w;
    logic [39:0] obs;
    logic        lohi_seen;
    lohi_seen = 1'b0;
    cu_bus.IR = {5'b01110, 27'h2A5A5A5};
    cu_bus.con_ff = 1'b0;
    push_instr(cu_bus.IR, 1'b0);
    for (int k = 0; k < 5; k++) begin
      exp_w = exp_q.pop_front();
      obs = observe();
      n_checks++;
      if (obs !== exp_w) begin
        n_fail++;
        $display("FAIL abort_mul step %0d: got %h expected %h", k, obs, exp_w);
      end
      if (cu_bus.LOin || cu_bus.HIin) lohi_seen = 1'b1;
      if (k == 4) clear = 1'b0;
      @(negedge clk); #1;
    end
    exp_q.delete();
    obs = observe();
    if (cu_bus.LOin || cu_bus.HIin) lohi_seen = 1'b1;
    n_checks++;
    if (obs !== 40'h0) begin
      n_fail++;
      $display("FAIL abort_reset_cycle: got %h expected %h", obs, 40'h0);
    end
    clear = 1'b1;
    @(negedge clk); #1;
    obs = observe();
    n_checks++;
    if (obs !== W_T0) begin
      n_fail++;
      $display("FAIL abort_refetch_t0: got %h expected %h", obs, W_T0);
    end
    n_checks++;
    if (lohi_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_lohi: got %b expected %b", lohi_seen, 1'b0);
    end
  endtask

  task automatic test_halt();
    logic [39:0] obs;
    run_instr({5'b11001, 27'h0}, 1'b0, 1'b0, -1, "halt");
    cu_bus.stop = 1'b1;
    repeat (20) begin
      obs = observe();
      n_checks++;
      if (obs !== 40'h0) begin
        n_fail++;
        $display("FAIL halt_hold: got %h expected %h", obs, 40'h0);
      end
      @(negedge clk); #1;
    end
    clear = 1'b0;
    @(negedge clk); #1;
    obs = observe();
    n_checks++;
    if (obs !== 40'h0) begin
      n_fail++;
      $display("FAIL halt_clear_reset: got %h expected %h", obs, 40'h0);
    end
    clear = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      obs = observe();
      n_checks++;
      if (obs !== 40'h0) begin
        n_fail++;
        $display("FAIL fetch_wait_hold: got %h expected %h", obs, 40'h0);
      end
    end
    cu_bus.stop = 1'b0;
    @(negedge clk); #1;
    obs = observe();
    n_checks++;
    if (obs !== W_T0) begin
      n_fail++;
      $display("FAIL fetch_wait_release: got %h expected %h", obs, W_T0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_spec_examples();
    test_all_opcodes();
    test_back_to_back();
    test_stop_boundary();
    test_clear_abort();
    test_halt();
    run_instr(32'h1A2B8000, 1'b0, 1'b1, -1, "after_halt_add");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
